fetch_unit: RTL and testbench

- Instruction-fetch and PC-sequencing stage for the single-issue MIPS core.
- Produces the instruction word and its opcode field (OP) that the control decoder consumes.
- Consumes the decoder's Jump, BranchEQ and BranchNE outputs, plus the ALU Zero flag, to choose the next PC.
- Talks to instruction memory over a single-outstanding request/ready handshake; no branch delay slot.

---
 rtl/mips_pkg.sv | 23 ++
 rtl/next_pc_calc.sv | 36 +++
 rtl/fetch_unit.sv | 83 ++++++++
 tb/tb_fetch_unit.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcode field values, reset fetch address, fetch-stage states.
// No logic of its own; imported by the fetch stage and the control decoder.
package mips_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

endpackage

// File: rtl/next_pc_calc.sv
// Next-PC selection: jump > taken branch > sequential, result word aligned.
// Purely combinational, no backpressure.
module next_pc_calc #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] pc_plus4,
  // only the jump index / branch immediate fields of the instruction matter here
  input  logic [25:0]           instr,
  input  logic                  jump,
  input  logic                  branch_eq,
  input  logic                  branch_ne,
  input  logic                  zero,
  output logic [ADDR_WIDTH-1:0] next_pc
);

  logic [ADDR_WIDTH-1:0] jumpTarget;
  logic [ADDR_WIDTH-1:0] branchTarget;
  logic [ADDR_WIDTH-1:0] target;
  logic                  branchTaken;

  always_comb begin
    jumpTarget   = {pc_plus4[ADDR_WIDTH-1:28], instr, 2'b00};
    branchTarget = pc_plus4 + {{(ADDR_WIDTH-18){instr[15]}}, instr[15:0], 2'b00};
    // both flags set means "branch on either outcome"
    branchTaken  = (branch_eq && zero) || (branch_ne && !zero);
    if (jump) begin
      target = jumpTarget;
    end else if (branchTaken) begin
      target = branchTarget;
    end else begin
      target = pc_plus4;
    end
    next_pc = target & ~ADDR_WIDTH'(3);
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch and PC sequencing, one outstanding imem request, no delay slot.
// Latency: 1 cycle reset->req, ready->instr_valid, accept->next req.
// Backpressure: instruction held frozen until instr_accept; imem stalls via imem_ready.
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int          ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_ready,
  input  logic [31:0]           imem_rdata,
  output logic [31:0]           instr,
  output logic [5:0]            op,
  output logic                  instr_valid,
  input  logic                  instr_accept,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [ADDR_WIDTH-1:0] pc_plus4,
  input  logic                  jump,
  input  logic                  branch_eq,
  input  logic                  branch_ne,
  input  logic                  zero
);

  localparam logic [ADDR_WIDTH-1:0] RESET_ADDR = ADDR_WIDTH'(RESET_PC);
  localparam logic [ADDR_WIDTH-1:0] STEP       = ADDR_WIDTH'(4);

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] nextPc;

  next_pc_calc #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) nextPcCalc (
    .pc_plus4 (pc_plus4),
    .instr    (instr[25:0]),
    .jump     (jump),
    .branch_eq(branch_eq),
    .branch_ne(branch_ne),
    .zero     (zero),
    .next_pc  (nextPc)
  );

  assign imem_req    = (state == FETCH);
  assign instr_valid = (state == HOLD);
  assign op          = instr[31:26];

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      imem_addr <= RESET_ADDR;
      instr     <= '0;
      pc        <= RESET_ADDR;
      pc_plus4  <= RESET_ADDR + STEP;
    end else begin
      case (state)
        IDLE: begin
          state     <= FETCH;
          imem_addr <= RESET_ADDR;
        end
        FETCH: begin
          if (imem_ready) begin
            instr    <= imem_rdata;
            pc       <= imem_addr;
            pc_plus4 <= imem_addr + STEP;
            state    <= HOLD;
          end
        end
        HOLD: begin
          // decoder/ALU inputs only matter in the accept cycle
          if (instr_accept) begin
            imem_addr <= nextPc;
            state     <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed program walk, randomized fetch/hold/accept
// traffic against an address-level reference model, reset abort and address wraparound.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset, imemReady, instrAccept, jump, branchEq, branchNe, zero;
  logic [31:0] imemRdata;
  logic        imemReq, instrValid;
  logic [31:0] imemAddr, instr, pc, pcPlus4;
  logic [5:0]  op;

  // second instance starting near the top of the address space
  logic        reset2, ready2, accept2, branchEq2, zero2;
  logic [31:0] rdata2;
  logic        req2, valid2;
  logic [31:0] addr2, instr2, pc2, pcPlus42;
  logic [5:0]  op2;

  int nChecks = 0;
  int nPass   = 0;

  logic [31:0] mem [logic [31:0]];
  logic [31:0] expAddr, expInstr, expPc;

  fetch_unit dut (
    .clk(clk), .reset(reset), .imem_req(imemReq), .imem_addr(imemAddr),
    .imem_ready(imemReady), .imem_rdata(imemRdata), .instr(instr), .op(op),
    .instr_valid(instrValid), .instr_accept(instrAccept), .pc(pc), .pc_plus4(pcPlus4),
    .jump(jump), .branch_eq(branchEq), .branch_ne(branchNe), .zero(zero)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .reset(reset2), .imem_req(req2), .imem_addr(addr2),
    .imem_ready(ready2), .imem_rdata(rdata2), .instr(instr2), .op(op2),
    .instr_valid(valid2), .instr_accept(accept2), .pc(pc2), .pc_plus4(pcPlus42),
    .jump(1'b0), .branch_eq(branchEq2), .branch_ne(1'b0), .zero(zero2)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs === exp) nPass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Architectural next-PC rule expressed with plain masks and signed arithmetic.
  function automatic logic [31:0] modelNext(input logic [31:0] pcp4, input logic [31:0] ins,
                                            input logic j, input logic be, input logic bn,
                                            input logic z);
    int off;
    if (j) return (pcp4 & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
    if ((be && z) || (bn && !z)) begin
      off = int'($signed(ins[15:0]));
      return pcp4 + 32'(off * 4);
    end
    return pcp4;
  endfunction

  // Service one request at expAddr after `waits` stall cycles.
  task automatic doFetch(input int waits);
    logic [31:0] word;
    word = mem.exists(expAddr) ? mem[expAddr] : $urandom;
    for (int i = 0; i <= waits; i++) begin
      checkVal("fetchReq", imemReq, 1);
      checkVal("fetchAddr", imemAddr, expAddr);
      checkVal("fetchValid", instrValid, 0);
      instrAccept = 1'($urandom_range(0, 1));
      imemReady   = (i == waits);
      imemRdata   = (i == waits) ? word : $urandom;
      tick();
    end
    imemReady   = 1'b0;
    instrAccept = 1'b0;
    expInstr    = word;
    expPc       = expAddr;
    checkVal("holdValid", instrValid, 1);
    checkVal("holdInstr", instr, expInstr);
    checkVal("holdOp", op, {26'd0, expInstr[31:26]});
    checkVal("holdPc", pc, expPc);
    checkVal("holdPcPlus4", pcPlus4, expPc + 32'd4);
    checkVal("holdReq", imemReq, 0);
  endtask

  // Stall `holds` cycles with noisy side inputs, then accept with the given controls.
  task automatic doAccept(input int holds, input logic j, input logic be, input logic bn,
                          input logic z);
    for (int h = 0; h < holds; h++) begin
      instrAccept = 1'b0;
      jump        = 1'($urandom_range(0, 1));
      zero        = 1'($urandom_range(0, 1));
      branchEq    = 1'($urandom_range(0, 1));
      imemReady   = 1'($urandom_range(0, 1));
      imemRdata   = $urandom;
      tick();
      checkVal("stallValid", instrValid, 1);
      checkVal("stallInstr", instr, expInstr);
      checkVal("stallPc", pc, expPc);
      checkVal("stallReq", imemReq, 0);
    end
    imemReady   = 1'b0;
    instrAccept = 1'b1;
    jump = j; branchEq = be; branchNe = bn; zero = z;
    expAddr = modelNext(expPc + 32'd4, expInstr, j, be, bn, z);
    tick();
    instrAccept = 1'b0;
    jump = 1'($urandom_range(0, 1)); branchEq = 1'($urandom_range(0, 1));
    branchNe = 1'($urandom_range(0, 1)); zero = 1'($urandom_range(0, 1));
    checkVal("nextReq", imemReq, 1);
    checkVal("nextAddr", imemAddr, expAddr);
    checkVal("nextValid", instrValid, 0);
  endtask

  initial begin
    reset = 1'b1; imemReady = 1'b0; imemRdata = '0; instrAccept = 1'b0;
    jump = 1'b0; branchEq = 1'b0; branchNe = 1'b0; zero = 1'b0;
    reset2 = 1'b1; ready2 = 1'b0; rdata2 = '0; accept2 = 1'b0; branchEq2 = 1'b0; zero2 = 1'b0;
    mem[32'h0040_0000] = 32'h2008_0005;
    mem[32'h0040_0004] = 32'h0810_0004;
    mem[32'h0040_0010] = 32'h1000_FFFF;
    mem[32'h0040_0014] = 32'h1000_0002;
    mem[32'h0040_0020] = 32'h0C10_0003;

    repeat (3) tick();
    checkVal("rstReq", imemReq, 0);
    checkVal("rstAddr", imemAddr, 32'h0040_0000);
    checkVal("rstInstr", instr, 0);
    checkVal("rstValid", instrValid, 0);
    checkVal("rstPc", pc, 32'h0040_0000);
    checkVal("rstPcPlus4", pcPlus4, 32'h0040_0004);

    reset = 1'b0;
    tick();
    expAddr = 32'h0040_0000;
    doFetch(1);
    checkVal("addiOp", op, 32'h08);
    doAccept(0, 0, 0, 0, 0);
    checkVal("seqAddr", imemAddr, 32'h0040_0004);
    doFetch(0);
    doAccept(0, 1, 0, 0, 0);
    doFetch(2);
    doAccept(1, 0, 1, 0, 1);
    checkVal("beqBack", imemAddr, 32'h0040_0010);
    doFetch(0);
    doAccept(0, 0, 1, 0, 0);
    checkVal("beqNotTaken", imemAddr, 32'h0040_0014);
    doFetch(0);
    doAccept(0, 0, 1, 1, 1);
    doFetch(0);
    checkVal("jalLink", pcPlus4, 32'h0040_0024);
    doAccept(0, 1, 0, 0, 0);
    checkVal("jalTarget", imemAddr, 32'h0040_000C);
    doFetch(5);
    doAccept(4, 0, 0, 0, 0);

    for (int n = 0; n < 40; n++) begin
      doFetch($urandom_range(0, 3));
      doAccept($urandom_range(0, 2), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // abandon a pending request; the ready arriving alongside reset must be dropped
    reset = 1'b1; imemReady = 1'b1; imemRdata = $urandom;
    tick();
    checkVal("abortValid", instrValid, 0);
    checkVal("abortReq", imemReq, 0);
    checkVal("abortAddr", imemAddr, 32'h0040_0000);
    reset = 1'b0;
    tick();
    imemReady = 1'b0;
    checkVal("lateReadyValid", instrValid, 0);
    expAddr = 32'h0040_0000;
    doFetch(0);

    reset2 = 1'b0;
    tick();
    checkVal("wrapReq", req2, 1);
    checkVal("wrapAddr", addr2, 32'hFFFF_FFFC);
    ready2 = 1'b1; rdata2 = 32'h1000_FFFE;
    tick();
    ready2 = 1'b0;
    checkVal("wrapValid", valid2, 1);
    checkVal("wrapPc", pc2, 32'hFFFF_FFFC);
    checkVal("wrapPcPlus4", pcPlus42, 32'h0000_0000);
    accept2 = 1'b1;
    tick();
    accept2 = 1'b0;
    checkVal("wrapSeq", addr2, 32'h0000_0000);
    ready2 = 1'b1;
    tick();
    ready2 = 1'b0;
    checkVal("zeroPc", pc2, 32'h0000_0000);
    accept2 = 1'b1; branchEq2 = 1'b1; zero2 = 1'b1;
    tick();
    accept2 = 1'b0; branchEq2 = 1'b0; zero2 = 1'b0;
    checkVal("negWrap", addr2, modelNext(32'h0000_0004, 32'h1000_FFFE, 0, 1, 0, 1));
    checkVal("negWrapReq", req2, 1);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
